// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: valid/ready word in, LSB-first serial frame out
// (start, DATA_BITS data, optional parity, STOP_BITS stop) with an internal baud divider.
//   state | meaning
//   IDLE  | line high, ready for a word
//   START | start bit (0)
//   DATA  | data bits, shift register bit 0 on the line
//   PAR   | parity bit (skipped when PARITY=0)
//   STOP  | stop bits (1); last cycle of the last one can accept the next word
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be at least 1");
  end

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = 1'b1;
    bit_end  = (baud_q == '0);
    tx_ready = (state_q == S_IDLE) ||
               (state_q == S_STOP && bit_q == STOP_LAST && bit_end);
    accept   = tx_valid && tx_ready;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? BAUD_LAST : baud_q - 1'b1;
    end

    case (state_q)
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == DATA_LAST) begin
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      S_PAR: if (bit_end) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_q == STOP_LAST) state_d = S_IDLE;
        else                    bit_d   = bit_q + 4'd1;
      end
      default: ;
    endcase

    // Acceptance overrides the end-of-frame return to IDLE, giving zero-gap chaining.
    if (accept) begin
      shift_d = tx_data;
      par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
      bit_d   = '0;
      baud_d  = BAUD_LAST;
      state_d = S_START;
    end

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations, expected line frames
// are queued at stimulus time and a monitor decodes the serial line mid-bit.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vld;
  logic [7:0] d0, d1, d3;
  logic [8:0] d2;
  logic [3:0] txo, rdy, bsy;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 8N1 /4   1: 8N2 /4   2: 9E1 /4   3: 8O1 /1
  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_data(d0),
    .tx_ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_data(d1),
    .tx_ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1]));
  uart_tx_frame #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_data(d2),
    .tx_ready(rdy[2]), .tx_out(txo[2]), .busy(bsy[2]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(vld[3]), .tx_data(d3),
    .tx_ready(rdy[3]), .tx_out(txo[3]), .busy(bsy[3]));

  typedef struct {
    int          id;
    int          len;
    logic [15:0] bits;
    int          gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_busy = 1'b0;

  function automatic int cpb_of(input int id);
    return (id == 3) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic put(input int id, input int len, input logic [15:0] bits, input int gap);
    exp_t e;
    e.id = id; e.len = len; e.bits = bits; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int id, input logic [8:0] w);
    case (id)
      0:       d0 = w[7:0];
      1:       d1 = w[7:0];
      2:       d2 = w;
      default: d3 = w[7:0];
    endcase
  endtask

  // Offer a word; returns just after the accepting edge (hold=1) or at the
  // following negedge with tx_valid dropped (hold=0).
  task automatic send(input int id, input logic [8:0] w, input bit hold);
    int n;
    @(negedge clk);
    vld[id] = 1'b1;
    drive(id, w);
    n = 0;
    while (rdy[id] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout id=%0d: tx_ready stayed low, expected high", id);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      @(negedge clk);
      vld[id] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin : monitor
    exp_t        e;
    int          n;
    int          cpb;
    int          last_start;
    logic [15:0] got;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e        = sb_q.pop_front();
        mon_busy = 1'b1;
        cpb      = cpb_of(e.id);
        n        = 0;
        while (txo[e.id] !== 1'b0 && n < 300) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (n >= 300) begin
          errors++;
          $display("FAIL start_timeout id=%0d: no start bit seen, expected frame %h", e.id, e.bits);
        end else begin
          if (e.gap != 0) begin
            checks++;
            if (cyc - last_start != e.gap) begin
              errors++;
              $display("FAIL chain_gap id=%0d: start-to-start %0d cycles, expected %0d",
                       e.id, cyc - last_start, e.gap);
            end
          end
          last_start = cyc;
          got = '0;
          n   = 0;
          for (int k = 0; k < e.len; k++) begin
            while (n < cpb * k + (cpb - 1) / 2) begin
              @(negedge clk);
              n++;
            end
            got[k] = txo[e.id];
          end
          if (got !== e.bits) begin
            errors++;
            $display("FAIL frame id=%0d: line bits %b, expected %b", e.id, got, e.bits);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    vld   = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", txo[0], 1);
    chk("rst_ready", rdy[0], 1);
    chk("rst_busy", bsy[0], 0);
    vld[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_accept", bsy[0], 0);
    vld[0] = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    // 8N1 0xA5 with ready/busy timing around the end of frame (F=40)
    put(0, 10, {1'b1, 8'hA5, 1'b0}, 0);
    send(0, 9'h0A5, 1'b0);
    chk("a5_ready_t0", rdy[0], 0);
    chk("a5_busy_t0", bsy[0], 1);
    repeat (38) @(negedge clk);
    chk("a5_ready_t38", rdy[0], 0);
    @(negedge clk);
    chk("a5_ready_t39", rdy[0], 1);
    chk("a5_busy_t39", bsy[0], 1);
    @(negedge clk);
    chk("a5_busy_t40", bsy[0], 0);
    chk("a5_ready_t40", rdy[0], 1);
    drain();

    // tx_data changes after acceptance must not reach the line
    put(0, 10, {1'b1, 8'h3C, 1'b0}, 0);
    send(0, 9'h03C, 1'b0);
    d0 = 8'hFF;
    drain();

    // Reset during data bit 3 of 0xF0, then a clean 0x81 frame
    send(0, 9'h0F0, 1'b0);
    repeat (17) @(negedge clk);
    chk("f0_bit3_level", txo[0], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx_out", txo[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_busy", bsy[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (txo[0] !== 1'b1 || bsy[0] !== 1'b0) n++;
    end
    chk("no_resume_cycles", n, 0);
    put(0, 10, {1'b1, 8'h81, 1'b0}, 0);
    send(0, 9'h081, 1'b0);
    drain();

    // 8N2 back-to-back with tx_valid held high: second start exactly 44 cycles later
    put(1, 11, {2'b11, 8'h55, 1'b0}, 0);
    put(1, 11, {2'b11, 8'hAA, 1'b0}, 44);
    send(1, 9'h055, 1'b1);
    send(1, 9'h0AA, 1'b0);
    drain();

    // 9 data bits, even parity
    put(2, 12, {1'b1, 1'b1, 9'h1FF, 1'b0}, 0);
    send(2, 9'h1FF, 1'b0);
    drain();
    put(2, 12, {1'b1, 1'b1, 9'h007, 1'b0}, 0);
    send(2, 9'h007, 1'b0);
    drain();

    // Odd parity at one clock per bit, chained (F=11)
    put(3, 11, {1'b1, 1'b0, 8'h07, 1'b0}, 0);
    put(3, 11, {1'b1, 1'b1, 8'h5A, 1'b0}, 11);
    send(3, 9'h007, 1'b1);
    send(3, 9'h05A, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
